sr_flag_arbiter: RTL

Round-robin controller that shares a bank of SR-style flag bits between several requesters. Each requester issues set/clear/hold commands against a flag index through a valid/ready handshake. The block serialises the commands, applies them to the flag bank, and treats the forbidden S=R=1 encoding as a counted error instead of driving an undefined value. It sits between control agents and any logic that consumes status/enable flags.

---
 rtl/sr_flag_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sr_flag_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/sr_flag_pkg.sv
// Shared encodings for the SR flag arbiter: command codes and controller states.
package sr_flag_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_CLR  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_ILL  = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any
);

  localparam int PW = $clog2(NREQ);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the search so no path leaves a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && valid[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Serialises set/clear commands from NREQ requesters onto a flag bank; S=R=1 and
// out-of-range indices are dropped and counted as errors.
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3,
  parameter int CNTW  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [2*NREQ-1:0]      req_cmd,
  input  logic [IDXW*NREQ-1:0]   req_idx,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   clr_all,
  output logic [NFLAG-1:0]       flags,
  output logic                   busy,
  output logic                   err_pulse,
  output logic [CNTW-1:0]        err_count
);

  localparam int PW = $clog2(NREQ);
  localparam logic [IDXW:0] LP_NFLAG = (IDXW+1)'(NFLAG);

  state_e           r_state, w_state_next;
  logic [PW-1:0]    r_ptr;
  cmd_e             r_cmd;
  logic [IDXW-1:0]  r_idx;
  logic [NFLAG-1:0] r_flags, w_flags_next;
  logic             r_err_pulse;
  logic [CNTW-1:0]  r_err_count;

  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_grant_idx;
  logic             w_any, w_xfer, w_illegal, w_err;
  logic [1:0]       w_win_cmd;
  logic [IDXW-1:0]  w_win_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .valid     (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  // Winner's command selected by the one-hot grant, so cmd/idx never feed ready.
  always_comb begin
    w_win_cmd = '0;
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_win_cmd = req_cmd[2*i +: 2];
        w_win_idx = req_idx[IDXW*i +: IDXW];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any) w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign w_xfer    = (r_state == ST_IDLE) && w_any;
  assign w_illegal = (r_cmd == CMD_ILL) || ({1'b0, r_idx} >= LP_NFLAG);
  assign w_err     = (r_state == ST_WRITE) && w_illegal;

  always_comb begin
    w_flags_next = r_flags;
    if (r_state == ST_WRITE && !w_illegal) begin
      for (int i = 0; i < NFLAG; i++) begin
        if (r_idx == IDXW'(i)) begin
          case (r_cmd)
            CMD_SET: w_flags_next[i] = 1'b1;
            CMD_CLR: w_flags_next[i] = 1'b0;
            default: ;
          endcase
        end
      end
    end
    if (clr_all) w_flags_next = '0;
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cmd       <= CMD_HOLD;
      r_idx       <= '0;
      r_flags     <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flags     <= w_flags_next;
      r_err_pulse <= w_err;
      if (w_err && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
      if (w_xfer) begin
        r_cmd <= cmd_e'(w_win_cmd);
        r_idx <= w_win_idx;
        r_ptr <= (w_grant_idx == PW'(NREQ-1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE && reset) ? w_grant : '0;
  assign flags     = r_flags;
  assign busy      = (r_state == ST_WRITE);
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule
